// File: rtl/present_rr_sched.sv
// Shared iterative PRESENT-80 engine serving two handshaked requesters round-robin.
// One block in flight; ciphertext returned on a valid/ready port tagged with the owner id.
module present_rr_sched #(
  parameter int unsigned ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [79:0] s0_key,
  input  logic [63:0] s0_pt,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [79:0] s1_key,
  input  logic [63:0] s1_pt,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_ct,
  output logic        m_id,
  output logic        busy
);

  localparam logic [4:0] LastRnd = 5'(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StOut} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic        grant_vld, grant;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // addRoundKey, sBoxLayer, then pLayer (bit i -> 16*i mod 63, bit 63 fixed).
  function automatic logic [63:0] round_enc(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] x, y;
    x = s ^ rk;
    for (int n = 0; n < 16; n++) x[4*n +: 4] = sbox(x[4*n +: 4]);
    y = '0;
    for (int i = 0; i < 63; i++) y[(i*16) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  always_comb begin
    grant_vld = s0_valid | s1_valid;
    grant     = (s0_valid && s1_valid) ? prio_q : s1_valid;
  end

  assign s0_ready = (fsm_q == StIdle) && !rst && grant_vld && !grant;
  assign s1_ready = (fsm_q == StIdle) && !rst && grant_vld && grant;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (fsm_q)
      StIdle: begin
        if (grant_vld) begin
          state_d = grant ? s1_pt : s0_pt;
          key_d   = grant ? s1_key : s0_key;
          rnd_d   = 5'd1;
          owner_d = grant;
          prio_d  = ~grant;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        state_d = round_enc(state_q, key_q[79:16]);
        key_d   = key_update(key_q, rnd_q);
        rnd_d   = rnd_q + 5'd1;
        if (rnd_q == LastRnd) fsm_d = StOut;
      end
      StOut: begin
        if (m_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Final whitening with the last scheduled round key.
  assign m_valid = (fsm_q == StOut);
  assign m_ct    = m_valid ? (state_q ^ key_q[79:16]) : 64'h0;
  assign m_id    = m_valid & owner_q;
  assign busy    = (fsm_q != StIdle);

endmodule

// File: tb/tb_present_rr_sched.sv
// Bench for present_rr_sched: known-answer vectors, contention, backpressure, reset and
// randomized traffic against an algorithmic PRESENT model with a round-robin grant model.
module tb_present_rr_sched;
  localparam int unsigned ROUNDS = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [79:0] s0_key, s1_key;
  logic [63:0] s0_pt, s1_pt;
  logic        m_valid, m_ready, m_id, busy;
  logic [63:0] m_ct;

  int n_checks = 0;
  int n_fail   = 0;
  logic prio_m;

  logic [3:0] sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  present_rr_sched #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_key   (s0_key),
    .s0_pt    (s0_pt),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_key   (s1_key),
    .s1_pt    (s1_pt),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_ct     (m_ct),
    .m_id     (m_id),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s, p;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= int'(ROUNDS); r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_t[s[4*n +: 4]];
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i*16) % 63] = s[i];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox_t[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Entered at a negedge after the accept edge; returns at the negedge of the next IDLE cycle.
  task automatic await_result(input logic exp_id, input logic [63:0] exp_ct, input int stall,
                              input bit perturb);
    int lat;
    logic [79:0] k0, k1;
    logic [63:0] p0, p1;
    k0 = s0_key; k1 = s1_key; p0 = s0_pt; p1 = s1_pt;
    m_ready = (stall == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_eq("busy_run", busy, 1'b1);
      if (perturb) begin
        s0_pt  = ~s0_pt;
        s1_key = ~s1_key;
        s0_key = s0_key ^ 80'h1;
        s1_pt  = s1_pt + 64'd1;
      end
    end while (!m_valid && lat < 200);
    check_eq("latency", 80'(lat), 80'(ROUNDS + 1));
    check_eq("m_id", m_id, exp_id);
    check_eq("m_ct", m_ct, exp_ct);
    check_eq("busy_out", busy, 1'b1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_vld", m_valid, 1'b1);
      check_eq("stall_ct", m_ct, exp_ct);
      check_eq("stall_rdy", {s0_ready, s1_ready}, 2'b00);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check_eq("drop_vld", m_valid, 1'b0);
    check_eq("drop_busy", busy, 1'b0);
    check_eq("idle_ct", m_ct, 64'h0);
    s0_key = k0; s1_key = k1; s0_pt = p0; s1_pt = p1;
  endtask

  // Called at a negedge in IDLE; drives valids, checks grant, then follows the block through.
  task automatic transact(input bit v0, input bit v1, input bit drop, input int stall,
                          input bit perturb, input bit use_kat, input logic [63:0] kat);
    logic g;
    logic [63:0] exp;
    s0_valid = v0;
    s1_valid = v1;
    g = (v0 && v1) ? prio_m : v1;
    exp = use_kat ? kat : (g ? present_enc(s1_key, s1_pt) : present_enc(s0_key, s0_pt));
    #1;
    check_eq("s0_ready", s0_ready, (v0 || v1) && !g);
    check_eq("s1_ready", s1_ready, (v0 || v1) && g);
    @(posedge clk);
    prio_m = ~g;
    #1;
    if (drop) begin
      if (g) s1_valid = 1'b0;
      else   s0_valid = 1'b0;
    end
    await_result(g, exp, stall, perturb);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; m_ready = 1'b0; prio_m = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b0;
    s0_key = '0; s0_pt = '0; s1_key = '0; s1_pt = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_s0_ready", s0_ready, 1'b0);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_ct", m_ct, 64'h0);
    check_eq("rst_m_id", m_id, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    s0_valid = 1'b0;

    // Known answers on each requester
    transact(1, 0, 1, 0, 0, 1, 64'h5579C1387B228445);
    s1_key = '1; s1_pt = '0;
    transact(0, 1, 1, 0, 0, 1, 64'hE72C46C0F5945049);
    s1_key = '0; s1_pt = '1;
    transact(0, 1, 1, 0, 0, 1, 64'hA112FFC72F68417B);
    s1_key = '1; s1_pt = '1;
    transact(0, 1, 1, 0, 0, 1, 64'h3333DCD3213210D2);

    // Backpressure with s1 pending; s1 must be granted in the first IDLE cycle afterwards
    s0_key = '1; s0_pt = '1;
    s1_key = '0; s1_pt = '1;
    transact(1, 1, 1, 10, 0, 1, 64'h3333DCD3213210D2);
    transact(0, 1, 1, 0, 0, 1, 64'hA112FFC72F68417B);

    // Inputs perturbed during RUN
    s0_key = 80'h0123456789ABCDEF0123; s0_pt = 64'hDEADBEEFCAFEF00D;
    transact(1, 0, 1, 2, 1, 0, 64'h0);

    // Contention from reset: grants alternate, accepts every ROUNDS+2 cycles
    rst = 1'b1; prio_m = 1'b0;
    s0_key = '0; s0_pt = '0; s1_key = '1; s1_pt = '0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      transact(1, 1, 0, 0, 0, 1, (i % 2 == 0) ? 64'h5579C1387B228445 : 64'hE72C46C0F5945049);
    s0_valid = 1'b0; s1_valid = 1'b0;

    // Reset mid-run discards the block and restores priority to requester 0
    s0_key = 80'hFEEDFACE000011112222; s0_pt = 64'h0123456789ABCDEF;
    s0_valid = 1'b1;
    #1;
    check_eq("mr_s0_ready", s0_ready, 1'b1);
    @(posedge clk);
    #1;
    s0_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prio_m = 1'b0;
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_m_valid", m_valid, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    check_eq("mr_no_output", 80'(seen), 80'd0);
    s0_key = '0; s0_pt = '0; s1_key = '1; s1_pt = '1;
    transact(1, 1, 1, 0, 0, 1, 64'h5579C1387B228445);
    s1_valid = 1'b0;

    // Randomized traffic; losers keep their request asserted
    for (int it = 0; it < 10; it++) begin
      if (!s0_valid && ($urandom() % 2 == 1)) begin
        s0_valid = 1'b1;
        s0_key = 80'({$urandom(), $urandom(), $urandom()});
        s0_pt  = {$urandom(), $urandom()};
      end
      if (!s1_valid && ($urandom() % 2 == 1)) begin
        s1_valid = 1'b1;
        s1_key = 80'({$urandom(), $urandom(), $urandom()});
        s1_pt  = {$urandom(), $urandom()};
      end
      if (!s0_valid && !s1_valid) begin
        s0_valid = 1'b1;
        s0_key = 80'({$urandom(), $urandom(), $urandom()});
        s0_pt  = {$urandom(), $urandom()};
      end
      transact(s0_valid, s1_valid, 1, int'($urandom_range(0, 3)), bit'($urandom() % 2),
               0, 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
